// File: rtl/tc_pkg.sv
// Width helpers shared by the storage components.
package tc_pkg;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/tc_wrap_counter.sv
// Modulo counter with explicit wrap; used for the queue read and write pointers.
module tc_wrap_counter
  import tc_pkg::*;
#(
  parameter int unsigned MODULUS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             inc,
  output logic [ptr_width(MODULUS)-1:0]    value
);

  localparam int unsigned PW = ptr_width(MODULUS);
  localparam logic [PW-1:0] Last = PW'(MODULUS - 1);

  logic [PW-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = (value_q == Last) ? '0 : value_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/tc_queue.sv
// FIFO with explicit occupancy register and sticky overflow/underflow flags.
module tc_queue
  import tc_pkg::*;
#(
  parameter int unsigned UUID      = 0,
  parameter string       NAME      = "",
  parameter int unsigned BIT_WIDTH = 1,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          push,
  input  logic                          pop,
  input  logic [BIT_WIDTH-1:0]          in,
  output logic [BIT_WIDTH-1:0]          out,
  output logic                          empty,
  output logic                          full,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  logic [BIT_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]        rd, wr;
  logic [CW-1:0]        count_d, count_q;
  logic                 overflow_d, overflow_q;
  logic                 underflow_d, underflow_q;
  logic                 do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A push at full is accepted only when a pop frees the head slot the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      if (push && full && !pop) overflow_d = 1'b1;
      if (pop && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr] <= in;
  end

  tc_wrap_counter #(
    .MODULUS(DEPTH)
  ) u_rd (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .inc  (do_pop),
    .value(rd)
  );

  tc_wrap_counter #(
    .MODULUS(DEPTH)
  ) u_wr (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .inc  (do_push),
    .value(wr)
  );

  assign out       = empty ? '0 : mem_q[rd];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_tc_queue.sv
// Directed bench for tc_queue with a reference queue as scoreboard.
module tb_tc_queue;

  logic       clk = 1'b0;
  logic       rst, clear;
  logic       push, pop;
  logic [7:0] in, out;
  logic       empty, full, overflow, underflow;
  logic [2:0] count;

  logic       push3, pop3;
  logic [7:0] in3, out3;
  logic       empty3, full3, overflow3, underflow3;
  logic [1:0] count3;

  int checks = 0;
  int failures = 0;

  logic [7:0] sb[$];
  logic [7:0] sb3[$];
  logic       m_ovf, m_unf;

  always #5 clk = ~clk;

  tc_queue #(.UUID(1), .NAME("q4"), .BIT_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop), .in(in),
    .out(out), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  tc_queue #(.UUID(2), .NAME("q3"), .BIT_WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .clear(1'b0), .push(push3), .pop(pop3), .in(in3),
    .out(out3), .empty(empty3), .full(full3), .count(count3),
    .overflow(overflow3), .underflow(underflow3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".out"}, 32'(out), (sb.size() != 0) ? 32'(sb[0]) : 32'h0);
    chk({tag, ".count"}, 32'(count), 32'(sb.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(sb.size() == 4));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic cycle(input string tag, input logic pu, input logic po,
                       input logic [7:0] d, input logic cl);
    logic e, f;
    @(negedge clk);
    push = pu; pop = po; in = d; clear = cl;
    e = (sb.size() == 0);
    f = (sb.size() == 4);
    // Scoreboard: a word leaving the queue must be the one presented at the head.
    if (rst && !cl && po && !e) chk({tag, ".popped"}, 32'(out), 32'(sb[0]));
    @(posedge clk);
    if (!rst || cl) begin
      sb.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (pu && po) begin
      if (e) m_unf = 1'b1;
      else void'(sb.pop_front());
      sb.push_back(d);
    end else if (pu) begin
      if (f) m_ovf = 1'b1;
      else sb.push_back(d);
    end else if (po) begin
      if (e) m_unf = 1'b1;
      else void'(sb.pop_front());
    end
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0;
    chk_state(tag);
  endtask

  task automatic cycle3(input string tag, input logic pu, input logic po, input logic [7:0] d);
    @(negedge clk);
    push3 = pu; pop3 = po; in3 = d;
    if (po && sb3.size() != 0) chk({tag, ".popped"}, 32'(out3), 32'(sb3[0]));
    @(posedge clk);
    if (po && sb3.size() != 0) void'(sb3.pop_front());
    if (pu && sb3.size() < 3) sb3.push_back(d);
    #1;
    push3 = 1'b0; pop3 = 1'b0;
    chk({tag, ".count"}, 32'(count3), 32'(sb3.size()));
    chk({tag, ".out"}, 32'(out3), (sb3.size() != 0) ? 32'(sb3[0]) : 32'h0);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; in = '0;
    push3 = 1'b0; pop3 = 1'b0; in3 = '0;
    m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    chk_state("reset0");

    // Held in reset: pushes must have no effect.
    for (int i = 0; i < 3; i++) cycle("rst_hold", 1'b1, 1'b0, 8'hA, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cycle("rst_rel", 1'b1, 1'b0, 8'hA, 1'b0);
    chk("rst_rel.outA", 32'(out), 32'hA);
    cycle("drain0", 1'b0, 1'b1, 8'h0, 1'b0);

    // Fill and drain.
    for (int i = 1; i <= 4; i++) cycle("fill", 1'b1, 1'b0, 8'(i), 1'b0);
    chk("fill.full", 32'(full), 32'h1);
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 1'b1, 8'h0, 1'b0);
    chk("drain.empty", 32'(empty), 32'h1);

    // Overflow: word 5 must never appear.
    for (int i = 1; i <= 4; i++) cycle("ofill", 1'b1, 1'b0, 8'(i), 1'b0);
    cycle("ovf", 1'b1, 1'b0, 8'h5, 1'b0);
    chk("ovf.flag", 32'(overflow), 32'h1);
    for (int i = 0; i < 4; i++) cycle("odrain", 1'b0, 1'b1, 8'h0, 1'b0);

    // Simultaneous push/pop at full.
    cycle("clr0", 1'b0, 1'b0, 8'h0, 1'b1);
    for (int i = 1; i <= 4; i++) cycle("sfill", 1'b1, 1'b0, 8'(i), 1'b0);
    cycle("simul", 1'b1, 1'b1, 8'h9, 1'b0);
    chk("simul.out2", 32'(out), 32'h2);
    for (int i = 0; i < 4; i++) cycle("sdrain", 1'b0, 1'b1, 8'h0, 1'b0);

    // Underflow, then push+pop on empty.
    cycle("unf", 1'b0, 1'b1, 8'h0, 1'b0);
    chk("unf.flag", 32'(underflow), 32'h1);
    cycle("unf_pp", 1'b1, 1'b1, 8'h7, 1'b0);
    chk("unf_pp.out7", 32'(out), 32'h7);
    cycle("unf_dr", 1'b0, 1'b1, 8'h0, 1'b0);

    // Clear mid-operation beats a concurrent push.
    for (int i = 1; i <= 3; i++) cycle("cfill", 1'b1, 1'b0, 8'(i + 16), 1'b0);
    cycle("clear", 1'b1, 1'b0, 8'h33, 1'b1);

    // Asynchronous reset mid-operation.
    cycle("afill", 1'b1, 1'b0, 8'h44, 1'b0);
    cycle("afill", 1'b1, 1'b0, 8'h45, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    sb.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    chk_state("async_rst");
    @(negedge clk);
    rst = 1'b1;

    // DEPTH=3 pointer wrap under sustained push+pop at full.
    for (int i = 1; i <= 3; i++) cycle3("w_fill", 1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 10; i++) cycle3("w_pp", 1'b1, 1'b1, 8'(8'h20 + i));
    for (int i = 0; i < 3; i++) cycle3("w_drain", 1'b0, 1'b1, 8'h0);
    chk("w.empty", 32'(empty3), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
